// File: rtl/hz_tone_classifier.sv
// Classifies per-second Hz counts into tone band A/B/none with N-sample confirmation.
// Optional stale-stream watchdog enabled by defining HZ_CLASS_TIMEOUT_EN.
module hz_tone_classifier #(
    parameter int unsigned A_LO          = 450,
    parameter int unsigned A_HI          = 550,
    parameter int unsigned B_LO          = 850,
    parameter int unsigned B_HI          = 950,
    parameter int unsigned CONFIRM_COUNT = 2
`ifdef HZ_CLASS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 150_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_second,
    input  logic [9:0] hz,
    output logic [1:0] tone,
    output logic       tone_valid,
    output logic       tone_changed,
    output logic       meas_strobe,
    output logic       stale
);

    typedef enum logic {S_NONE, S_LOCKED} state_t;

    localparam logic [2:0] CC   = 3'(CONFIRM_COUNT);
    localparam logic [9:0] ALOV = 10'(A_LO);
    localparam logic [9:0] AHIV = 10'(A_HI);
    localparam logic [9:0] BLOV = 10'(B_LO);
    localparam logic [9:0] BHIV = 10'(B_HI);

    state_t     state, state_n;
    logic       prev_sec, armed, sample_pending, toggle;
    logic [1:0] band, cand, cand_n, tone_n;
    logic [2:0] cnt, cnt_n;
    logic       changed_n;
    logic       timeout_hit;

    // armed masks the first cycle out of reset so a toggle coincident with release is ignored
    assign toggle = armed && (one_second != prev_sec);

    always_comb begin
        band = 2'b00;
        if (hz >= ALOV && hz <= AHIV)
            band = 2'b01;
        else if (hz >= BLOV && hz <= BHIV)
            band = 2'b10;
    end

    always_comb begin
        cand_n    = cand;
        cnt_n     = cnt;
        state_n   = state;
        tone_n    = tone;
        changed_n = 1'b0;
        if (sample_pending) begin
            if (band == cand) begin
                cnt_n = (cnt < CC) ? cnt + 3'd1 : CC;
            end else begin
                cand_n = band;
                cnt_n  = 3'd1;
            end
            case (state)
                S_NONE: begin
                    if (cand_n != 2'b00 && cnt_n == CC) begin
                        state_n   = S_LOCKED;
                        tone_n    = cand_n;
                        changed_n = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (cand_n != tone && cnt_n == CC) begin
                        tone_n    = cand_n;
                        changed_n = 1'b1;
                        state_n   = (cand_n == 2'b00) ? S_NONE : S_LOCKED;
                    end
                end
                default: state_n = S_NONE;
            endcase
        end else if (timeout_hit) begin
            state_n   = S_NONE;
            tone_n    = 2'b00;
            cnt_n     = '0;
            changed_n = (tone != 2'b00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sec       <= one_second;
            armed          <= 1'b0;
            sample_pending <= 1'b0;
            state          <= S_NONE;
            cand           <= '0;
            cnt            <= '0;
            tone           <= '0;
            tone_valid     <= 1'b0;
            tone_changed   <= 1'b0;
            meas_strobe    <= 1'b0;
        end else begin
            prev_sec       <= one_second;
            armed          <= 1'b1;
            sample_pending <= toggle;
            state          <= state_n;
            cand           <= cand_n;
            cnt            <= cnt_n;
            tone           <= tone_n;
            tone_valid     <= (tone_n != 2'b00);
            tone_changed   <= changed_n;
            meas_strobe    <= sample_pending;
        end
    end

`ifdef HZ_CLASS_TIMEOUT_EN
    localparam logic [27:0] TO_V = 28'(TIMEOUT_CYCLES);
    logic [27:0] wd;

    // watchdog parks at TO_V so the timeout fires only once per silent period
    assign timeout_hit = !toggle && (wd == TO_V - 28'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd    <= '0;
            stale <= 1'b0;
        end else begin
            if (toggle)
                wd <= '0;
            else if (wd != TO_V)
                wd <= wd + 28'd1;
            if (sample_pending)
                stale <= 1'b0;
            else if (timeout_hit)
                stale <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign stale       = 1'b0;
`endif

endmodule

// File: tb/tb_hz_tone_classifier.sv
// Directed + randomized bench for hz_tone_classifier against a sample-history tone model.
module tb_hz_tone_classifier;
    localparam int CC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       one_second;
    logic [9:0] hz;
    logic [1:0] tone;
    logic       tone_valid, tone_changed, meas_strobe, stale;

    int n_checks = 0;
    int n_errors = 0;

    int         hist[$];
    logic [1:0] m_tone;

    always #5 clk = ~clk;

`ifdef HZ_CLASS_TIMEOUT_EN
    hz_tone_classifier #(.CONFIRM_COUNT(CC), .TIMEOUT_CYCLES(1000)) dut (
`else
    hz_tone_classifier #(.CONFIRM_COUNT(CC)) dut (
`endif
        .clk(clk), .rst(rst), .one_second(one_second), .hz(hz),
        .tone(tone), .tone_valid(tone_valid), .tone_changed(tone_changed),
        .meas_strobe(meas_strobe), .stale(stale)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] band_of(input int v);
        if (v >= 450 && v <= 550) return 2'b01;
        if (v >= 850 && v <= 950) return 2'b10;
        return 2'b00;
    endfunction

    // Tone becomes band b whenever the last CC samples since reset all fall in b.
    task automatic model_push(input int v);
        bit same;
        hist.push_back(band_of(v));
        if (hist.size() >= CC) begin
            same = 1'b1;
            for (int i = hist.size() - CC; i < hist.size(); i++)
                if (hist[i] != hist[hist.size() - 1]) same = 1'b0;
            if (same) m_tone = 2'(hist[hist.size() - 1]);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        m_tone = 2'b00;
    endtask

    task automatic do_sample(input int v, input string tag);
        logic [1:0] old;
        old = m_tone;
        model_push(v);
        @(negedge clk);
        one_second = ~one_second;
        hz = 10'(v);
        @(posedge clk); #1;
        check({tag, "/strobe_early"}, meas_strobe, 0);
        @(posedge clk); #1;
        check({tag, "/strobe"}, meas_strobe, 1);
        check({tag, "/tone"}, tone, m_tone);
        check({tag, "/valid"}, tone_valid, m_tone != 2'b00);
        check({tag, "/changed"}, tone_changed, m_tone != old);
        check({tag, "/stale"}, stale, 0);
        @(posedge clk); #1;
        check({tag, "/strobe_end"}, meas_strobe, 0);
        check({tag, "/changed_end"}, tone_changed, 0);
    endtask

    initial begin
        int bvals[8];
        int v, prev_v, cyc, pulses;
        logic [1:0] old;

        rst = 1'b1; one_second = 1'b0; hz = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset/tone", tone, 0);
        check("reset/valid", tone_valid, 0);
        check("reset/changed", tone_changed, 0);
        check("reset/strobe", meas_strobe, 0);
        check("reset/stale", stale, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        do_sample(500, "lockA1");
        do_sample(500, "lockA2");
        do_sample(700, "glitch700");
        do_sample(500, "back500");
        do_sample(900, "toB1");
        do_sample(900, "toB2");
        do_sample(0, "toNone1");
        do_sample(0, "toNone2");

        bvals = '{449, 450, 550, 551, 850, 950, 951, 1023};
        foreach (bvals[i]) begin
            do_sample(bvals[i], $sformatf("bound%0d_a", bvals[i]));
            do_sample(bvals[i], $sformatf("bound%0d_b", bvals[i]));
        end

        // back-to-back toggles with hz held, from locked A
        do_sample(500, "b2b_pre1");
        do_sample(500, "b2b_pre2");
        old = m_tone;
        model_push(900);
        model_push(900);
        @(negedge clk); one_second = ~one_second; hz = 10'd900;
        @(posedge clk); #1;
        check("b2b/strobe0", meas_strobe, 0);
        @(negedge clk); one_second = ~one_second;
        @(posedge clk); #1;
        check("b2b/strobe1", meas_strobe, 1);
        check("b2b/tone1", tone, old);
        check("b2b/changed1", tone_changed, 0);
        @(posedge clk); #1;
        check("b2b/strobe2", meas_strobe, 1);
        check("b2b/tone2", tone, m_tone);
        check("b2b/changed2", tone_changed, 1);
        @(posedge clk); #1;
        check("b2b/strobe3", meas_strobe, 0);

        prev_v = 500;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: v = 450 + int'($urandom_range(0, 100));
                1: v = 850 + int'($urandom_range(0, 100));
                2: v = int'($urandom_range(0, 1023));
                default: v = prev_v;
            endcase
            prev_v = v;
            do_sample(v, $sformatf("rand%0d_hz%0d", n, v));
        end

        repeat (3) do_sample(900, "preRstB");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("asyncrst/tone", tone, 0);
        check("asyncrst/valid", tone_valid, 0);
        check("asyncrst/changed", tone_changed, 0);
        check("asyncrst/strobe", meas_strobe, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        one_second = ~one_second;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("release_toggle/strobe%0d", k), meas_strobe, 0);
            check($sformatf("release_toggle/changed%0d", k), tone_changed, 0);
        end
        do_sample(500, "postRst1");
        do_sample(500, "postRst2");

`ifdef HZ_CLASS_TIMEOUT_EN
        cyc = 0; pulses = 0;
        while (stale !== 1'b1 && cyc < 1200) begin
            @(posedge clk); #1;
            cyc++;
            if (tone_changed === 1'b1) pulses++;
        end
        check("timeout/latency_in_window", (cyc >= 990 && cyc <= 1005), 1);
        check("timeout/stale", stale, 1);
        check("timeout/tone", tone, 0);
        check("timeout/valid", tone_valid, 0);
        check("timeout/pulses", pulses, 1);
        model_clear();
        do_sample(500, "afterTimeout1");
        check("timeout/stale_cleared", stale, 0);
        do_sample(500, "afterTimeout2");
`else
        cyc = 0; pulses = 0;
        repeat (2000) begin
            @(posedge clk); #1;
            cyc++;
            if (tone_changed === 1'b1) pulses++;
        end
        check("idle/tone_holds", tone, m_tone);
        check("idle/no_pulses", pulses, 0);
        check("idle/stale", stale, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
